bus_master: RTL and testbench

- Initiator end of the synth register bus: BusAddress, BusData, BusReadWrite, BusClock.
- Takes single-beat read/write commands from a local controller (MIDI/UART front end, sequencer) over a valid/ready handshake.
- Runs one complete bus transaction per command, generating the BusClock edge that channel responders sample on.
- Returns read data, or write completion, as a one-cycle response.

---
 rtl/synth_bus_pkg.sv | 24 ++
 rtl/bus_phase_timer.sv | 37 +++
 rtl/bus_master.sv | 135 +++++++++++++
 tb/tb_bus_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_bus_pkg.sv
// Shared definitions for the synth register bus: widths, direction encoding
// and the transaction state encoding used by the master and the responders.
package synth_bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    localparam logic BUS_READ  = 1'b0;
    localparam logic BUS_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RESP  = 3'd4
    } bus_state_e;

    // True in the three timed phases where the phase counter runs.
    function automatic logic bus_phase_active(input bus_state_e s);
        return (s == ST_SETUP) || (s == ST_HIGH) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Down-counter that times one bus phase of CLKDIV cycles; tc_o marks the
// last cycle of the phase, after which the counter reloads itself.
module bus_phase_timer #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || (en_i && (cnt_q == '0))) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/bus_master.sv
// Initiator for the synth register bus: turns one valid/ready command into a
// SETUP/HIGH/HOLD bus cycle with a single BusClock strobe, then a response pulse.
module bus_master
    import synth_bus_pkg::*;
#(
    parameter int unsigned            CLKDIV    = 4,
    parameter logic [BUS_ADDR_W-1:0]  IDLE_ADDR = 16'hFFFF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdWrite,
    input  logic [BUS_ADDR_W-1:0] CmdAddr,
    input  logic [BUS_DATA_W-1:0] CmdData,
    output logic                  RspValid,
    output logic                  RspRead,
    output logic [BUS_DATA_W-1:0] RspData,
    output logic [BUS_ADDR_W-1:0] BusAddress,
    inout  wire  [BUS_DATA_W-1:0] BusData,
    output logic                  BusReadWrite,
    output logic                  BusClock
);

    bus_state_e state_q, state_d;
    logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic                  bus_rw_q, bus_rw_d;
    logic                  bus_oe_q, bus_oe_d;
    logic                  bus_clk_q, bus_clk_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_read_q, rsp_read_d;
    logic [BUS_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  accept;
    logic                  phase_tc;

    assign CmdReady = (state_q == ST_IDLE) && Reset;
    assign accept   = CmdValid && CmdReady;

    bus_phase_timer #(.CLKDIV(CLKDIV)) u_timer (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .load_i (accept),
        .en_i   (bus_phase_active(state_q)),
        .tc_o   (phase_tc)
    );

    // Bus outputs are computed for the next state so every pin is a flop output.
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_rw_d    = bus_rw_q;
        bus_oe_d    = bus_oe_q;
        bus_clk_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_read_d  = rsp_read_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SETUP;
                    bus_addr_d  = CmdAddr;
                    bus_rw_d    = CmdWrite;
                    bus_oe_d    = (CmdWrite == BUS_WRITE);
                    bus_wdata_d = (CmdWrite == BUS_WRITE) ? CmdData : '0;
                end
            end
            ST_SETUP: begin
                if (phase_tc) begin
                    state_d   = ST_HIGH;
                    bus_clk_d = 1'b1;
                end
            end
            ST_HIGH: begin
                bus_clk_d = 1'b1;
                if (phase_tc) begin
                    state_d   = ST_HOLD;
                    bus_clk_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (phase_tc) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_read_d  = (bus_rw_q == BUS_READ);
                    rsp_data_d  = (bus_rw_q == BUS_READ) ? BusData : '0;
                    bus_addr_d  = IDLE_ADDR;
                    bus_rw_d    = BUS_WRITE;
                    bus_oe_d    = 1'b1;
                    bus_wdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            bus_addr_q  <= IDLE_ADDR;
            bus_wdata_q <= '0;
            bus_rw_q    <= BUS_WRITE;
            bus_oe_q    <= 1'b1;
            bus_clk_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_read_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_rw_q    <= bus_rw_d;
            bus_oe_q    <= bus_oe_d;
            bus_clk_q   <= bus_clk_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_read_q  <= rsp_read_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign BusAddress   = bus_addr_q;
    assign BusReadWrite = bus_rw_q;
    assign BusClock     = bus_clk_q;
    assign BusData      = bus_oe_q ? bus_wdata_q : 'z;
    assign RspValid     = rsp_valid_q;
    assign RspRead      = rsp_read_q;
    assign RspData      = rsp_data_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: CLKDIV=4 and CLKDIV=1 instances, each with a simple
// register-file responder on addresses 0x01xx.
module tb_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        sel = 1'b0;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;

    logic        ready4, ready1, rspv4, rspv1, rspr4, rspr1;
    logic [7:0]  rspd4, rspd1;
    logic [15:0] addr4, addr1;
    logic        rw4, rw1, bclk4, bclk1;
    wire  [7:0]  data4, data1;
    logic        valid4, valid1;

    logic [7:0]  mem4 [256];
    logic [7:0]  mem1 [256];

    int          total = 0;
    int          bad = 0;
    int          rise_cnt [2];
    int          rsp_cnt [2];
    int          viol [2];
    time         rise_t [2];
    time         fall_t [2];
    logic [7:0]  fall_data [2];
    logic        pclk [2];
    logic        prw [2];

    always #5 clk = ~clk;

    assign valid4 = cmd_valid && !sel;
    assign valid1 = cmd_valid && sel;

    bus_master #(.CLKDIV(4), .IDLE_ADDR(16'hFFFF)) dut4 (
        .Clock(clk), .Reset(rst_n), .CmdValid(valid4), .CmdReady(ready4),
        .CmdWrite(cmd_write), .CmdAddr(cmd_addr), .CmdData(cmd_data),
        .RspValid(rspv4), .RspRead(rspr4), .RspData(rspd4),
        .BusAddress(addr4), .BusData(data4), .BusReadWrite(rw4), .BusClock(bclk4)
    );

    bus_master #(.CLKDIV(1), .IDLE_ADDR(16'hFFFF)) dut1 (
        .Clock(clk), .Reset(rst_n), .CmdValid(valid1), .CmdReady(ready1),
        .CmdWrite(cmd_write), .CmdAddr(cmd_addr), .CmdData(cmd_data),
        .RspValid(rspv1), .RspRead(rspr1), .RspData(rspd1),
        .BusAddress(addr1), .BusData(data1), .BusReadWrite(rw1), .BusClock(bclk1)
    );

    // Responders drive read data whenever the master releases the bus on their range.
    assign data4 = (!rw4 && addr4[15:8] == 8'h01) ? mem4[addr4[7:0]] : 8'hzz;
    assign data1 = (!rw1 && addr1[15:8] == 8'h01) ? mem1[addr1[7:0]] : 8'hzz;

    always @(posedge bclk4) begin
        rise_cnt[0] = rise_cnt[0] + 1;
        rise_t[0] = $time;
        if (rw4 && addr4[15:8] == 8'h01) mem4[addr4[7:0]] = data4;
    end
    always @(posedge bclk1) begin
        rise_cnt[1] = rise_cnt[1] + 1;
        rise_t[1] = $time;
        if (rw1 && addr1[15:8] == 8'h01) mem1[addr1[7:0]] = data1;
    end
    always @(negedge bclk4) begin fall_t[0] = $time; fall_data[0] = data4; end
    always @(negedge bclk1) begin fall_t[1] = $time; fall_data[1] = data1; end

    always @(negedge clk) begin
        if (rspv4) rsp_cnt[0] = rsp_cnt[0] + 1;
        if (rspv1) rsp_cnt[1] = rsp_cnt[1] + 1;
        if ((bclk4 || pclk[0]) && rw4 != prw[0]) viol[0] = viol[0] + 1;
        if ((bclk1 || pclk[1]) && rw1 != prw[1]) viol[1] = viol[1] + 1;
        pclk[0] = bclk4; prw[0] = rw4;
        pclk[1] = bclk1; prw[1] = rw1;
    end

    function automatic void check(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic cur_ready();
        return sel ? ready1 : ready4;
    endfunction

    // Called on a negedge; returns just after the accepting posedge.
    task automatic start_cmd(input logic w, input logic [15:0] a, input logic [7:0] d,
                             output time t_acc);
        int n = 0;
        cmd_write = w; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        while (!cur_ready() && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready()) check("accept_timeout", 1, 0);
        @(posedge clk);
        t_acc = $time;
    endtask

    task automatic wait_rsp(output time t_rsp);
        int  n = 0;
        logic seen = 1'b0;
        t_rsp = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = sel ? rspv1 : rspv4;
        end
        if (!seen) check("rsp_timeout", 1, 0);
        t_rsp = $time - 5;
    endtask

    task automatic run_one(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input logic exp_read, input logic [7:0] exp_data);
        int  idx = sel ? 1 : 0;
        int  c = sel ? 1 : 4;
        int  r0 = rise_cnt[idx];
        time t0, tr;
        start_cmd(w, a, d, t0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data = ~d;
        wait_rsp(tr);
        check("rsp_latency", longint'((tr - t0) / 10), 3 * c);
        check("busclk_rise", longint'((rise_t[idx] - t0) / 10), c);
        check("busclk_fall", longint'((fall_t[idx] - t0) / 10), 2 * c);
        check("edge_count", rise_cnt[idx] - r0, 1);
        check("rsp_read", sel ? rspr1 : rspr4, exp_read);
        check("rsp_data", sel ? rspd1 : rspd4, exp_data);
        if (w) begin
            check("wdata_at_fall", fall_data[idx], d);
            check("responder_reg", sel ? mem1[a[7:0]] : mem4[a[7:0]], d);
        end
        $display("txn clkdiv=%0d %s addr=%h data=%h rsp_read=%0b rsp_data=%h",
                 c, w ? "WR" : "RD", a, d, sel ? rspr1 : rspr4, sel ? rspd1 : rspd4);
        @(negedge clk);
    endtask

    // CmdValid stays high across both commands; the second must wait for the first.
    task automatic run_b2b(input logic [15:0] wa, input logic [7:0] wd,
                           input logic [15:0] ra, input logic [7:0] exp_rd);
        int  idx = sel ? 1 : 0;
        int  c = sel ? 1 : 4;
        int  r0 = rise_cnt[idx];
        time t0, t1, tr;
        start_cmd(1'b1, wa, wd, t0);
        @(negedge clk);
        start_cmd(1'b0, ra, 8'hEE, t1);
        check("b2b_accept_gap", longint'((t1 - t0) / 10), 3 * c + 2);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(tr);
        check("b2b_rsp_latency", longint'((tr - t1) / 10), 3 * c);
        check("b2b_busclk_rise", longint'((rise_t[idx] - t1) / 10), c);
        check("b2b_edge_count", rise_cnt[idx] - r0, 2);
        check("b2b_rsp_read", sel ? rspr1 : rspr4, 1);
        check("b2b_rsp_data", sel ? rspd1 : rspd4, exp_rd);
        check("b2b_first_write", sel ? mem1[wa[7:0]] : mem4[wa[7:0]], wd);
        $display("txn clkdiv=%0d b2b WR %h=%h then RD %h -> %h",
                 c, wa, wd, ra, sel ? rspd1 : rspd4);
        @(negedge clk);
    endtask

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        logic        exp_read;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [6];

    initial begin
        time t0;
        int  r0, s0;
        for (int i = 0; i < 256; i++) begin
            mem4[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem4[3] = 8'h33;
        for (int i = 0; i < 2; i++) begin
            rise_cnt[i] = 0; rsp_cnt[i] = 0; viol[i] = 0;
            rise_t[i] = 0; fall_t[i] = 0; fall_data[i] = '0;
            pclk[i] = 1'b0; prw[i] = 1'b1;
        end
        vecs[0] = '{1'b1, 16'h0101, 8'h5A, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 16'h0103, 8'h00, 1'b1, 8'h33};
        vecs[2] = '{1'b1, 16'h0104, 8'hC3, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 16'h0104, 8'hFF, 1'b1, 8'hC3};
        vecs[4] = '{1'b0, 16'h0101, 8'h12, 1'b1, 8'h5A};
        vecs[5] = '{1'b1, 16'h01FF, 8'hA5, 1'b0, 8'h00};

        // Reset held with a command pending
        #1;
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0101; cmd_data = 8'hAA;
        repeat (4) @(negedge clk);
        check("rst_busclk", bclk4, 0);
        check("rst_rw", rw4, 1);
        check("rst_addr", addr4, 16'hFFFF);
        check("rst_data", data4, 8'h00);
        check("rst_ready", ready4, 0);
        check("rst_rspvalid", rspv4, 0);
        check("rst_edges", rise_cnt[0], 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", ready4, 1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_read, vecs[i].exp_data);
        end

        run_b2b(16'h0106, 8'h7E, 16'h0103, 8'h33);

        // Abort in HIGH
        r0 = rise_cnt[0];
        s0 = rsp_cnt[0];
        start_cmd(1'b1, 16'h0110, 8'h77, t0);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("abort_in_high", bclk4, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busclk_drop", bclk4, 0);
        check("abort_addr", addr4, 16'hFFFF);
        repeat (20) @(negedge clk);
        check("abort_no_rsp", rsp_cnt[0] - s0, 0);
        check("abort_edges", rise_cnt[0] - r0, 1);
        $display("txn clkdiv=4 WR 0110 aborted by reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_one(1'b1, 16'h0102, 8'h9C, 1'b0, 8'h00);

        sel = 1'b1;
        @(negedge clk);
        run_one(1'b1, 16'h0108, 8'h3C, 1'b0, 8'h00);
        run_one(1'b0, 16'h0108, 8'h00, 1'b1, 8'h3C);
        run_b2b(16'h0105, 8'h11, 16'h0105, 8'h11);

        check("rw_stable_c4", viol[0], 0);
        check("rw_stable_c1", viol[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
